// File: rtl/scan_index_sequencer.sv
// Scan sequencer driving a one-hot line decoder: steps en/in through the masked lines with a programmable dwell.
// Define SCAN_INDEX_SEQUENCER_GAP_EN to insert a one-cycle en=0 gap between consecutive lines.
module scan_index_sequencer #(
  parameter int IDX_W   = 4,
  parameter int DWELL_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                continuous,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic [2**IDX_W-1:0] line_mask,
  output logic                en,
  output logic [IDX_W-1:0]    in,
  output logic                busy,
  output logic                frame_done
);

  localparam int N = 2**IDX_W;

`ifdef SCAN_INDEX_SEQUENCER_GAP_EN
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACTIVE} state_t;
`endif

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]       mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               cont_q, cont_d;

  logic [DWELL_W-1:0] dwell_eff;
  logic [IDX_W-1:0]   start_idx, first_idx, next_idx;
  logic               start_found, first_found, next_found;
  logic               advance;

  // Lowest set bit of m at position >= lo; found flag in the MSB of the result.
  function automatic logic [IDX_W:0] lowest_from(input logic [N-1:0] m, input int lo);
    logic [IDX_W:0] r;
    r = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (m[k] && (k >= lo)) r = {1'b1, IDX_W'(k)};
    end
    return r;
  endfunction

  always_comb begin
    {start_found, start_idx} = lowest_from(line_mask, 0);
    {first_found, first_idx} = lowest_from(mask_q, 0);
    {next_found, next_idx}   = lowest_from(mask_q, int'(idx_q) + 1);
    dwell_eff = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cont_d  = cont_q;
    advance = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          mask_d  = line_mask;
          dwell_d = dwell;
          cont_d  = continuous;
          if (start_found) begin
            state_d = ACTIVE;
            idx_d   = start_idx;
            en_d    = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = DWELL_W'(1);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (cnt_q >= dwell_eff) begin
`ifdef SCAN_INDEX_SEQUENCER_GAP_EN
          state_d = GAP;
          en_d    = 1'b0;
          cnt_d   = '0;
`else
          advance = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
`ifdef SCAN_INDEX_SEQUENCER_GAP_EN
      GAP: advance = 1'b1;
`endif
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase

    // Frame end wraps to the lowest line in continuous mode, otherwise returns to idle.
    if (advance) begin
      if (next_found) begin
        state_d = ACTIVE;
        idx_d   = next_idx;
        en_d    = 1'b1;
        cnt_d   = DWELL_W'(1);
      end else begin
        done_d = 1'b1;
        if (cont_q && first_found) begin
          state_d = ACTIVE;
          idx_d   = first_idx;
          en_d    = 1'b1;
          cnt_d   = DWELL_W'(1);
        end else begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
    end

    if (stop) begin
      state_d = IDLE;
      idx_d   = idx_q;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mask_q  <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      cont_q  <= cont_d;
    end
  end

  assign en         = en_q;
  assign in         = idx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_scan_index_sequencer.sv
// Bench for scan_index_sequencer: expected per-cycle traces are built from the line list of each frame.
module tb_scan_index_sequencer;

  localparam int IDX_W   = 4;
  localparam int DWELL_W = 8;
  localparam int N       = 16;

`ifdef SCAN_INDEX_SEQUENCER_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst, start, stop, continuous;
  logic [DWELL_W-1:0] dwell;
  logic [N-1:0]       line_mask;
  logic               en;
  logic [IDX_W-1:0]   in_idx;
  logic               busy, frame_done;

  always #5 clk = ~clk;

  scan_index_sequencer #(.IDX_W(IDX_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .dwell(dwell), .line_mask(line_mask), .en(en), .in(in_idx), .busy(busy),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic       en;
    logic [3:0] idx;
    logic       busy;
    logic       fd;
  } exp_t;

  exp_t       trace[$];
  logic [3:0] model_in;
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic exp_t mk(input logic e, input logic [3:0] i, input logic b, input logic f);
    exp_t r;
    r.en = e; r.idx = i; r.busy = b; r.fd = f;
    return r;
  endfunction

  // Expected cycle-by-cycle outputs after a start: each listed line for D cycles (+gap), frames repeated if continuous.
  function automatic void build_trace(input logic [N-1:0] m, input logic [7:0] dw, input logic c);
    int d;
    int lines[$];
    int frame;
    trace.delete();
    d = (dw == 0) ? 1 : int'(dw);
    for (int k = 0; k < N; k++) if (m[k]) lines.push_back(k);
    if (lines.size() == 0) begin
      trace.push_back(mk(1'b0, model_in, 1'b0, 1'b1));
      return;
    end
    frame = 0;
    do begin
      for (int i = 0; i < lines.size(); i++) begin
        for (int j = 0; j < d; j++)
          trace.push_back(mk(1'b1, 4'(lines[i]), 1'b1, (frame > 0 && i == 0 && j == 0)));
        if (GAP) trace.push_back(mk(1'b0, 4'(lines[i]), 1'b1, 1'b0));
      end
      frame++;
    end while (c && trace.size() < 300);
    if (!c) trace.push_back(mk(1'b0, 4'(lines[lines.size()-1]), 1'b0, 1'b1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input exp_t e);
    n_cmp++;
    assert (en === e.en) else begin
      n_bad++;
      $error("[TB] FAIL %s.en observed=%0b expected=%0b", tag, en, e.en);
    end
    n_cmp++;
    assert (in_idx === e.idx) else begin
      n_bad++;
      $error("[TB] FAIL %s.in observed=%0d expected=%0d", tag, in_idx, e.idx);
    end
    n_cmp++;
    assert (busy === e.busy) else begin
      n_bad++;
      $error("[TB] FAIL %s.busy observed=%0b expected=%0b", tag, busy, e.busy);
    end
    n_cmp++;
    assert (frame_done === e.fd) else begin
      n_bad++;
      $error("[TB] FAIL %s.frame_done observed=%0b expected=%0b", tag, frame_done, e.fd);
    end
  endtask

  // noise: 0 quiet, 1 random config/start while busy, 2 start with mask 0002 while busy.
  task automatic applyStimulus(input string tag, input logic [N-1:0] m, input logic [7:0] dw,
                               input logic c, input int stop_at, input int stop_idx, input int noise);
    line_mask = m; dwell = dw; continuous = c; stop = 1'b0; start = 1'b1;
    build_trace(m, dw, c);
    for (int i = 0; i < trace.size(); i++) begin
      tick();
      start = 1'b0;
      checkOutput(tag, trace[i]);
      model_in = trace[i].idx;
      if ((stop_at > 0 && i == stop_at - 1) ||
          (stop_idx >= 0 && trace[i].en && int'(trace[i].idx) == stop_idx)) begin
        stop  = 1'b1;
        start = (noise != 0) ? 1'($urandom % 2) : 1'b0;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        checkOutput({tag, "/stop"}, mk(1'b0, model_in, 1'b0, 1'b0));
        break;
      end
      if (noise == 1 && trace[i].busy) begin
        line_mask = 16'($urandom); dwell = 8'($urandom); continuous = 1'($urandom);
        start = 1'($urandom);
      end else if (noise == 2 && trace[i].busy) begin
        line_mask = 16'h0002; start = 1'b1;
      end
    end
    repeat (2) begin
      tick();
      start = 1'b0;
      checkOutput({tag, "/idle"}, mk(1'b0, model_in, 1'b0, 1'b0));
    end
  endtask

  initial begin
    logic [N-1:0] m;
    logic [7:0]   dw;
    logic         c;
    int           sa;

    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    dwell = '0; line_mask = '0; model_in = '0;
    repeat (2) begin
      tick();
      checkOutput("reset", mk(1'b0, 4'd0, 1'b0, 1'b0));
    end
    rst = 1'b0;
    repeat (5) begin
      tick();
      checkOutput("post_reset", mk(1'b0, 4'd0, 1'b0, 1'b0));
    end

    applyStimulus("mask0005", 16'h0005, 8'd3, 1'b0, 0, -1, 0);
    applyStimulus("mask8001_cont", 16'h8001, 8'd0, 1'b1, 12, -1, 0);
    applyStimulus("mask_zero", 16'h0000, 8'd2, 1'b0, 0, -1, 0);
    applyStimulus("ffff_stop5", 16'hFFFF, 8'd4, 1'b1, 0, 5, 0);
    applyStimulus("restart", 16'hFFFF, 8'd1, 1'b0, 0, -1, 0);
    applyStimulus("single_cont", 16'h0400, 8'd2, 1'b1, 9, -1, 0);
    applyStimulus("midstart", 16'h0005, 8'd2, 1'b0, 0, -1, 2);

    // Simultaneous stop and start in idle must not launch a frame.
    line_mask = 16'h0001; dwell = 8'd1; continuous = 1'b1;
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    checkOutput("stop_start", mk(1'b0, model_in, 1'b0, 1'b0));
    tick();
    checkOutput("stop_start2", mk(1'b0, model_in, 1'b0, 1'b0));

    // Reset in the middle of a frame.
    line_mask = 16'h00F0; dwell = 8'd2; continuous = 1'b1;
    build_trace(16'h00F0, 8'd2, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("pre_rst0", trace[0]);
    tick();
    checkOutput("pre_rst1", trace[1]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_in = '0;
    checkOutput("mid_rst", mk(1'b0, 4'd0, 1'b0, 1'b0));

    for (int r = 0; r < 12; r++) begin
      case ($urandom % 4)
        0:       m = '0;
        1:       m = 16'(1) << ($urandom % 16);
        default: m = 16'($urandom);
      endcase
      dw = 8'($urandom_range(0, 4));
      c  = 1'($urandom);
      if (c) sa = int'($urandom_range(1, 60));
      else   sa = ($urandom % 2) ? int'($urandom_range(1, 40)) : 0;
      applyStimulus("random", m, dw, c, sa, -1, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
